// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared sizes and types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_t;

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - ALU and load writeback request handshakes.
interface regfile_wb_arbiter_if #(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int AW    = regfile_pkg::AW
);

  logic             alu_valid;
  logic [AW-1:0]    alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             alu_ready;

  logic             ld_valid;
  logic [AW-1:0]    ld_rd;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - busy bitmap of registers awaiting load data, with stall query.
module wb_scoreboard #(
  parameter  int DEPTH = regfile_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             inflight_en,
  input  logic [AW-1:0]    inflight_addr,
  output logic [DEPTH-1:0] busy,
  output logic             stall
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             hit1;
  logic             hit2;

  // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign hit1 = (rs1_addr != '0) &&
                (busy_q[rs1_addr] || (inflight_en && (inflight_addr == rs1_addr)));
  assign hit2 = (rs2_addr != '0) &&
                (busy_q[rs2_addr] || (inflight_en && (inflight_addr == rs2_addr)));

  assign busy  = busy_q;
  assign stall = hit1 || hit2;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load writeback arbiter with write stage and scoreboard.
// Define WB_FWD_EN to expose write-stage forwarding and drop the in-flight stall term.
module regfile_wb_arbiter #(
  parameter  int WIDTH = regfile_pkg::WIDTH,
  parameter  int DEPTH = regfile_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic              stall,
  output logic              we0,
  output logic [AW-1:0]     wr_addr0,
  output logic [WIDTH-1:0]  wr_din0,
`ifdef WB_FWD_EN
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [WIDTH-1:0]  fwd_data1,
  output logic [WIDTH-1:0]  fwd_data2,
`endif
  output logic [DEPTH-1:0]  busy
);
  import regfile_pkg::*;

  wb_src_t last_grant;
  wb_src_t src_q;
  logic    grant_alu;
  logic    grant_ld;
  logic    inflight_en;

  // On conflict the requester that did not win the previous conflict goes first.
  assign grant_ld  = wb.ld_valid && (!wb.alu_valid || (last_grant == WB_SRC_ALU));
  assign grant_alu = wb.alu_valid && !grant_ld;

  assign wb.alu_ready = grant_alu;
  assign wb.ld_ready  = grant_ld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      we0        <= 1'b0;
      wr_addr0   <= '0;
      wr_din0    <= '0;
      last_grant <= WB_SRC_ALU;
      src_q      <= WB_SRC_ALU;
    end else begin
      if (wb.alu_valid && wb.ld_valid)
        last_grant <= grant_ld ? WB_SRC_LD : WB_SRC_ALU;
      if (grant_ld) begin
        we0      <= (wb.ld_rd != '0);
        wr_addr0 <= wb.ld_rd;
        wr_din0  <= wb.ld_data;
        src_q    <= WB_SRC_LD;
      end else if (grant_alu) begin
        we0      <= (wb.alu_rd != '0);
        wr_addr0 <= wb.alu_rd;
        wr_din0  <= wb.alu_data;
        src_q    <= WB_SRC_ALU;
      end else begin
        we0 <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign inflight_en = 1'b0;
  assign fwd_hit1    = we0 && (wr_addr0 == rs1_addr) && (rs1_addr != '0);
  assign fwd_hit2    = we0 && (wr_addr0 == rs2_addr) && (rs2_addr != '0);
  assign fwd_data1   = wr_din0;
  assign fwd_data2   = wr_din0;
`else
  assign inflight_en = we0;
`endif

  // Only load retires release a busy register; ALU writes never set one.
  wb_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .set_en        (issue_valid),
    .set_addr      (issue_rd),
    .clr_en        (we0 && (src_q == WB_SRC_LD)),
    .clr_addr      (wr_addr0),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .inflight_en   (inflight_en),
    .inflight_addr (wr_addr0),
    .busy          (busy),
    .stall         (stall)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef WB_FWD_EN
  localparam bit INFL = 1'b0;
`else
  localparam bit INFL = 1'b1;
`endif

  logic        clk;
  logic        rst;
  logic        issue_valid;
  reg_addr_t   issue_rd;
  reg_addr_t   rs1_addr;
  reg_addr_t   rs2_addr;
  logic        stall;
  logic        we0;
  reg_addr_t   wr_addr0;
  logic [31:0] wr_din0;
  logic [31:0] busy;
`ifdef WB_FWD_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int checks;
  int failures;

  regfile_wb_arbiter_if wb ();

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb.slave),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .stall       (stall),
    .we0         (we0),
    .wr_addr0    (wr_addr0),
    .wr_din0     (wr_din0),
`ifdef WB_FWD_EN
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_lr;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_din;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2,
    input logic e_ar, input logic e_lr, input logic e_stall,
    input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_din, input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.lv = lv; v.lr = lr; v.ld = ld;
    v.iv = iv; v.ir = ir; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_stall = e_stall;
    v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb.alu_valid = v.av; wb.alu_rd = v.ar; wb.alu_data = v.ad;
    wb.ld_valid  = v.lv; wb.ld_rd  = v.lr; wb.ld_data  = v.ld;
    issue_valid  = v.iv; issue_rd  = v.ir;
    rs1_addr     = v.r1; rs2_addr  = v.r2;
  endtask

  initial begin
    vec_t idle;
    checks   = 0;
    failures = 0;
    idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,0);
    rst = 1'b0;
    drive(idle);

    //  alu           ld             issue  rs1 rs2  ar lr st  we addr din          busy
    tv.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,           0,0, 0,0, 1,0,0,    1,5,32'hDEADBEEF,32'h0));
    tv.push_back(mk(0,0,0,            0,0,0,           0,0, 5,0, 0,0,INFL, 0,5,32'hDEADBEEF,32'h0));
    tv.push_back(mk(1,3,32'hA3A3A3A3, 1,4,32'hB4B4B4B4, 0,0, 0,0, 0,1,0,    1,4,32'hB4B4B4B4,32'h0));
    tv.push_back(mk(1,3,32'hA3A3A3A3, 1,4,32'hB4B4B4B4, 0,0, 0,0, 1,0,0,    1,3,32'hA3A3A3A3,32'h0));
    tv.push_back(mk(1,3,32'hA3A3A3A3, 1,4,32'hB4B4B4B4, 0,0, 0,0, 0,1,0,    1,4,32'hB4B4B4B4,32'h0));
    tv.push_back(mk(0,0,0,            1,0,32'h1234,    0,0, 0,0, 0,1,0,    0,0,32'h1234,    32'h0));
    tv.push_back(mk(0,0,0,            0,0,0,           1,7, 0,0, 0,0,0,    0,0,32'h1234,    32'h80));
    tv.push_back(mk(0,0,0,            0,0,0,           0,0, 7,0, 0,0,1,    0,0,32'h1234,    32'h80));
    tv.push_back(mk(0,0,0,            1,7,32'h77,      0,0, 7,0, 0,1,1,    1,7,32'h77,      32'h80));
    tv.push_back(mk(0,0,0,            0,0,0,           0,0, 7,0, 0,0,1,    0,7,32'h77,      32'h0));
    tv.push_back(mk(0,0,0,            0,0,0,           0,0, 7,0, 0,0,0,    0,7,32'h77,      32'h0));
    tv.push_back(mk(0,0,0,            0,0,0,           1,9, 0,0, 0,0,0,    0,7,32'h77,      32'h200));
    tv.push_back(mk(0,0,0,            1,9,32'h99,      0,0, 0,0, 0,1,0,    1,9,32'h99,      32'h200));
    tv.push_back(mk(0,0,0,            0,0,0,           1,9, 0,9, 0,0,1,    0,9,32'h99,      32'h200));
    tv.push_back(mk(0,0,0,            0,0,0,           1,0, 0,0, 0,0,0,    0,9,32'h99,      32'h200));
    tv.push_back(mk(0,0,0,            1,9,32'h5,       0,0, 0,0, 0,1,0,    1,9,32'h5,       32'h200));
    tv.push_back(mk(0,0,0,            0,0,0,           1,7, 0,0, 0,0,0,    0,9,32'h5,       32'h80));
    tv.push_back(mk(1,2,32'hCAFE,     0,0,0,           0,0, 0,0, 1,0,0,    1,2,32'hCAFE,    32'h80));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_we0",   {31'b0, we0}, 32'h0);
    chk("reset_addr",  {27'b0, wr_addr0}, 32'h0);
    chk("reset_din",   wr_din0, 32'h0);
    chk("reset_busy",  busy, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'b0, wb.alu_ready}, {31'b0, tv[i].e_ar});
      chk($sformatf("v%0d_ld_ready", i),  {31'b0, wb.ld_ready},  {31'b0, tv[i].e_lr});
      chk($sformatf("v%0d_stall", i),     {31'b0, stall},        {31'b0, tv[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we0", i),   {31'b0, we0},      {31'b0, tv[i].e_we});
      chk($sformatf("v%0d_addr", i),  {27'b0, wr_addr0}, {27'b0, tv[i].e_addr});
      chk($sformatf("v%0d_din", i),   wr_din0,           tv[i].e_din);
      chk($sformatf("v%0d_busy", i),  busy,              tv[i].e_busy);
    end

    // Reset while a write to r2 is in flight and r7 is busy.
    @(negedge clk);
    drive(idle);
    rs1_addr = 5'd2;
    rst = 1'b0;
`ifdef WB_FWD_EN
    #1;
    chk("pre_rst_fwd_hit1",  {31'b0, fwd_hit1}, 32'h1);
    chk("pre_rst_fwd_data1", fwd_data1, 32'hCAFE);
`endif
    @(posedge clk);
    #1;
    chk("midrst_we0",  {31'b0, we0}, 32'h0);
    chk("midrst_busy", busy, 32'h0);
    chk("midrst_din",  wr_din0, 32'h0);
    chk("midrst_addr", {27'b0, wr_addr0}, 32'h0);
`ifdef WB_FWD_EN
    chk("midrst_fwd_hit1", {31'b0, fwd_hit1}, 32'h0);
`endif

    // After reset the first conflict goes to the load unit again.
    @(negedge clk);
    rst = 1'b1;
    rs1_addr = 5'd7;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd1; wb.alu_data = 32'h11;
    wb.ld_valid  = 1'b1; wb.ld_rd  = 5'd6; wb.ld_data  = 32'h66;
    #1;
    chk("postrst_stall",     {31'b0, stall}, 32'h0);
    chk("postrst_ld_ready",  {31'b0, wb.ld_ready}, 32'h1);
    chk("postrst_alu_ready", {31'b0, wb.alu_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_addr", {27'b0, wr_addr0}, 32'h6);
    chk("postrst_din",  wr_din0, 32'h66);
    @(negedge clk);
    drive(idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
